// File: rtl/phase_sequencer.sv
// Multi-phase machine-cycle sequencer: one-hot phase strobes in round-robin order,
// with control-unit hold, IO pause handshake at cycle boundaries and single-step mode.
module phase_sequencer #(
    parameter int NUM_PHASES = 3,
    parameter int HOLD_PHASE = 1,
    parameter int CNT_W      = 16,
    localparam int PHASE_W   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  i_CLOCK,
    input  logic                  i_RESET_N,
    input  logic                  i_CUCPAUSE,
    input  logic                  i_IOPAUSE,
    input  logic                  i_STEP_MODE,
    input  logic                  i_STEP,
    output logic [NUM_PHASES-1:0] o_PHASE_EN,
    output logic [NUM_PHASES-1:0] o_PHASE_TOGGLE,
    output logic [PHASE_W-1:0]    o_PHASE,
    output logic [1:0]            o_STATE,
    output logic                  o_IOPAUSE_ACK,
    output logic [CNT_W-1:0]      o_CYCLE_COUNT
);

    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_RUN      = 2'd1,
        ST_IOWAIT   = 2'd2,
        ST_STEPWAIT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [NUM_PHASES-1:0]   en_q, en_d;
    logic [NUM_PHASES-1:0]   tog_q;
    logic                    ack_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    cnt_inc;
    logic                    at_hold;
    logic                    at_last;

    assign at_hold = (phase_q == PHASE_W'(HOLD_PHASE));
    assign at_last = (phase_q == PHASE_W'(NUM_PHASES - 1));

    // The hold is tested before the boundary so a hold on the last phase defers the count.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_inc = 1'b0;
        unique case (state_q)
            ST_START: begin
                state_d = ST_RUN;
                phase_d = '0;
            end
            ST_RUN: begin
                if (at_hold && i_CUCPAUSE) begin
                    phase_d = phase_q;
                end else if (!at_last) begin
                    phase_d = phase_q + PHASE_W'(1);
                end else begin
                    cnt_inc = 1'b1;
                    phase_d = '0;
                    if (i_IOPAUSE) begin
                        state_d = ST_IOWAIT;
                    end else if (i_STEP_MODE) begin
                        state_d = ST_STEPWAIT;
                    end
                end
            end
            ST_IOWAIT: begin
                phase_d = '0;
                if (!i_IOPAUSE) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEPWAIT: begin
                phase_d = '0;
                if (i_IOPAUSE) begin
                    state_d = ST_IOWAIT;
                end else if (i_STEP || !i_STEP_MODE) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_START;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        en_d = '0;
        if (state_d == ST_RUN) begin
            en_d = NUM_PHASES'(1) << phase_d;
        end
    end

    // Toggle bits flip on the same edge that raises the matching strobe.
    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q <= ST_START;
            phase_q <= '0;
            en_q    <= '0;
            tog_q   <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            tog_q   <= tog_q ^ en_d;
            ack_q   <= (state_d == ST_IOWAIT);
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_PHASE_EN     = en_q;
    assign o_PHASE_TOGGLE = tog_q;
    assign o_PHASE        = phase_q;
    assign o_STATE        = state_q;
    assign o_IOPAUSE_ACK  = ack_q;
    assign o_CYCLE_COUNT  = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: two instances (3 phases / hold on 1 / 4-bit count and
// 5 phases / hold on last / 16-bit count) driven together and scored against a reference model.
module tb_phase_sequencer;

    localparam int EXP_W = 2 + 16 + 16 + 4 + 1 + 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic cucpause, iopause, step_mode, step;

    logic [2:0]  en0, tog0;
    logic [1:0]  ph0, st0;
    logic        ack0;
    logic [3:0]  cnt0;
    logic [4:0]  en1, tog1;
    logic [2:0]  ph1;
    logic [1:0]  st1;
    logic        ack1;
    logic [15:0] cnt1;

    phase_sequencer #(.NUM_PHASES(3), .HOLD_PHASE(1), .CNT_W(4)) dut0 (
        .i_CLOCK(clk), .i_RESET_N(rst_n), .i_CUCPAUSE(cucpause), .i_IOPAUSE(iopause),
        .i_STEP_MODE(step_mode), .i_STEP(step), .o_PHASE_EN(en0), .o_PHASE_TOGGLE(tog0),
        .o_PHASE(ph0), .o_STATE(st0), .o_IOPAUSE_ACK(ack0), .o_CYCLE_COUNT(cnt0)
    );

    phase_sequencer #(.NUM_PHASES(5), .HOLD_PHASE(4), .CNT_W(16)) dut1 (
        .i_CLOCK(clk), .i_RESET_N(rst_n), .i_CUCPAUSE(cucpause), .i_IOPAUSE(iopause),
        .i_STEP_MODE(step_mode), .i_STEP(step), .o_PHASE_EN(en1), .o_PHASE_TOGGLE(tog1),
        .o_PHASE(ph1), .o_STATE(st1), .o_IOPAUSE_ACK(ack1), .o_CYCLE_COUNT(cnt1)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit io_lvl = 1'b0;

    logic [EXP_W-1:0] exp_q0[$];
    logic [EXP_W-1:0] exp_q1[$];

    // Reference model: mode 0=start 1=run 2=iowait 3=stepwait.
    int          np_tab[2] = '{3, 5};
    int          hp_tab[2] = '{1, 4};
    int          cw_tab[2] = '{4, 16};
    int          m_mode[2];
    int          m_phase[2];
    int          m_cnt[2];
    logic [15:0] m_tog[2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]  = 0;
            m_phase[i] = 0;
            m_cnt[i]   = 0;
            m_tog[i]   = 16'd0;
        end
    endfunction

    function automatic void model_step(input int i, input bit io, input bit cuc,
                                       input bit sm, input bit stp);
        case (m_mode[i])
            0: begin m_mode[i] = 1; m_phase[i] = 0; end
            1: begin
                if (m_phase[i] == hp_tab[i] && cuc) begin
                    // held: same phase strobed again
                end else if (m_phase[i] < np_tab[i] - 1) begin
                    m_phase[i] = m_phase[i] + 1;
                end else begin
                    m_cnt[i]   = (m_cnt[i] + 1) % (1 << cw_tab[i]);
                    m_phase[i] = 0;
                    if (io) m_mode[i] = 2;
                    else if (sm) m_mode[i] = 3;
                end
            end
            2: if (!io) begin m_mode[i] = 1; m_phase[i] = 0; end
            default: begin
                if (io) m_mode[i] = 2;
                else if (stp || !sm) begin m_mode[i] = 1; m_phase[i] = 0; end
            end
        endcase
        if (m_mode[i] != 1) m_phase[i] = 0;
        else m_tog[i][m_phase[i]] = ~m_tog[i][m_phase[i]];
    endfunction

    function automatic logic [EXP_W-1:0] model_out(input int i);
        logic [15:0] en;
        logic        ack;
        en  = 16'd0;
        if (m_mode[i] == 1) en = 16'd1 << m_phase[i];
        ack = (m_mode[i] == 2);
        return {2'(m_mode[i]), en, m_tog[i], 4'(m_phase[i]), ack, 16'(m_cnt[i])};
    endfunction

    function automatic logic [EXP_W-1:0] dut_out(input int i);
        if (i == 0) return {st0, 16'(en0), 16'(tog0), 4'(ph0), ack0, 16'(cnt0)};
        return {st1, 16'(en1), 16'(tog1), 4'(ph1), ack1, cnt1};
    endfunction

    task automatic compare(input string name, input int i, input logic [EXP_W-1:0] exp);
        logic [EXP_W-1:0] got;
        got = dut_out(i);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, i, $time, got, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a new output word; pop and compare.
    task automatic check_one(input int i);
        logic [EXP_W-1:0] exp;
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL queue_underrun dut%0d @%0t: got empty queue expected entry", i, $time);
        end else begin
            exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            compare("cycle_outputs", i, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_one(0);
            check_one(1);
        end
    end

    task automatic push_expected();
        exp_q0.push_back(model_out(0));
        exp_q1.push_back(model_out(1));
    endtask

    // Drives inputs for the next edge and records the outputs that edge must produce.
    task automatic cycle(input bit io, input bit cuc, input bit sm, input bit stp);
        @(posedge clk);
        #1;
        iopause   = io;
        cucpause  = cuc;
        step_mode = sm;
        step      = stp;
        for (int i = 0; i < 2; i++) model_step(i, io, cuc, sm, stp);
        push_expected();
    endtask

    // Called just after a rising edge with reset asserted.
    task automatic start_after_reset();
        model_reset();
        exp_q0.delete();
        exp_q1.delete();
        iopause = 0; cucpause = 0; step_mode = 0; step = 0;
        rst_n = 1'b1;
        push_expected();
        for (int i = 0; i < 2; i++) model_step(i, 0, 0, 0, 0);
        push_expected();
        mon_en = 1'b1;
    endtask

    // Called just after a rising edge; asserts reset between edges and checks at once.
    task automatic async_reset();
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        model_reset();
        compare("async_reset", 0, model_out(0));
        compare("async_reset", 1, model_out(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        start_after_reset();
    endtask

    task automatic steer_timeout(input string name, input bit reached);
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL %s_timeout @%0t: got not reached expected reached", name, $time);
        end
    endtask

    initial begin
        bit io, cuc, sm, stp;
        int regime;
        rst_n = 1'b0;
        iopause = 0; cucpause = 0; step_mode = 0; step = 0;
        @(posedge clk);
        #1;
        model_reset();
        compare("reset_values", 0, model_out(0));
        compare("reset_values", 1, model_out(1));
        @(posedge clk);
        #1;
        start_after_reset();

        repeat (9) cycle(0, 0, 0, 0);
        repeat (6) cycle(0, 1, 0, 0);
        repeat (4) cycle(0, 0, 0, 0);
        repeat (7) cycle(1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0);
        repeat (8) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        repeat (8) cycle(0, 0, 1, 0);
        repeat (3) cycle(1, 0, 1, 0);
        repeat (6) cycle(0, 0, 0, 0);
        repeat (60) cycle(0, 0, 0, 0);

        // Reset in the middle of a cycle, on phase 2 with ack low.
        for (int k = 0; k < 40; k++) begin
            if (m_mode[0] == 1 && m_phase[0] == 2) break;
            cycle(0, 0, 0, 0);
        end
        steer_timeout("reach_phase2", m_mode[0] == 1 && m_phase[0] == 2);
        @(posedge clk);
        #1;
        async_reset();

        // Reset while parked in IOWAIT.
        repeat (4) cycle(0, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            if (m_mode[0] == 2) break;
            cycle(1, 0, 0, 0);
        end
        steer_timeout("reach_iowait", m_mode[0] == 2);
        @(posedge clk);
        #1;
        async_reset();

        for (int r = 0; r < 40; r++) begin
            regime = $urandom_range(0, 2);
            for (int c = 0; c < 40; c++) begin
                cuc = ($urandom_range(0, 2) == 0);
                case (regime)
                    0: begin
                        io = ($urandom_range(0, 15) == 0); sm = 0; stp = 0;
                    end
                    1: begin
                        io  = ($urandom_range(0, 19) == 0);
                        sm  = ($urandom_range(0, 7) != 0);
                        stp = ($urandom_range(0, 3) == 0);
                    end
                    default: begin
                        if ($urandom_range(0, 4) == 0) io_lvl = ~io_lvl;
                        io  = io_lvl;
                        sm  = 1'($urandom_range(0, 1));
                        stp = 1'($urandom_range(0, 1));
                    end
                endcase
                cycle(io, cuc, sm, stp);
                if ($urandom_range(0, 199) == 0) async_reset();
            end
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised multi-phase cycle sequencer that drives the CPU's phase-enable strobes from a single system clock. It generates NUM_PHASES mutually exclusive, single-cycle phase enables in round-robin order, with per-phase toggle outputs for legacy consumers. It adds a control-unit hold on a selectable phase, an IO pause request/acknowledge handshake at cycle boundaries, single-step mode and a completed-cycle counter. It sits between the clock/reset pins and the control unit, register file and IO blocks.

## Interface
- NUM_PHASES, 3, number of phases per machine cycle; legal range 2..16
- HOLD_PHASE, 1, phase index (0-based) on which i_CUCPAUSE may stretch the cycle; must be < NUM_PHASES
- CNT_W, 16, width of the completed-cycle counter
- (localparam) PHASE_W = max(1, $clog2(NUM_PHASES))
- i_CLOCK  in  1  system clock; all logic on its rising edge
- i_RESET_N  in  1  reset; one clock; reset is asynchronous and active-low
- i_CUCPAUSE  in  1  control-unit hold request, sampled only while HOLD_PHASE is strobed
- i_IOPAUSE  in  1  IO pause request, level; honoured at cycle boundaries
- i_STEP_MODE  in  1  single-step mode enable, level
- i_STEP  in  1  advance one machine cycle while step-waiting, sampled per edge
- o_PHASE_EN  out  NUM_PHASES  one-hot phase strobe; all-zero outside RUN
- o_PHASE_TOGGLE  out  NUM_PHASES  bit p inverts each time o_PHASE_EN[p] is asserted
- o_PHASE  out  PHASE_W  current phase index; 0 outside RUN
- o_STATE  out  2  START=0, RUN=1, IOWAIT=2, STEPWAIT=3
- o_IOPAUSE_ACK  out  1  high exactly while in IOWAIT
- o_CYCLE_COUNT  out  CNT_W  number of completed machine cycles, wraps

## Operation
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (i_RESET_N low, immediately): state START, phase 0, o_PHASE_EN=0, o_PHASE_TOGGLE=0, o_PHASE=0, o_IOPAUSE_ACK=0, o_CYCLE_COUNT=0.
- START: at the first edge after reset release, go to RUN at phase 0.
- RUN, current phase p: o_PHASE_EN = 1<<p, o_PHASE=p. At the edge:
  - p==HOLD_PHASE and i_CUCPAUSE=1: stay at p. The strobe repeats and the toggle bit inverts again.
  - else p<NUM_PHASES-1: go to p+1.
  - else (last phase, a boundary): increment o_CYCLE_COUNT mod 2^CNT_W. Then:
    - i_IOPAUSE=1: go to IOWAIT.
    - else i_STEP_MODE=1: go to STEPWAIT.
    - else: go to RUN phase 0.
- If HOLD_PHASE == NUM_PHASES-1, the hold takes priority over the boundary. The counter does not increment while held.
- IOWAIT: no strobes, ack high. At an edge with i_IOPAUSE=0, go to RUN phase 0, ignoring step mode. One cycle then executes before any step-wait.
- STEPWAIT: no strobes. At the edge, priority order:
  - i_IOPAUSE=1: go to IOWAIT.
  - else i_STEP=1 or i_STEP_MODE=0: go to RUN phase 0.
- o_PHASE_TOGGLE[p] is updated on the same edge that asserts o_PHASE_EN[p].
- i_CUCPAUSE is ignored outside HOLD_PHASE. i_STEP is ignored outside STEPWAIT. i_IOPAUSE mid-cycle takes effect only at the next boundary.
- Reset asserted mid-cycle aborts immediately to reset values, with no partial-cycle count.

## Timing
- Reset release before edge E0: E0 moves to RUN, so o_PHASE_EN[0] is high in the cycle after E0. Free-running, the first strobe is 1 cycle after the first edge.
- Free-running period: NUM_PHASES cycles per machine cycle, plus 1 cycle per hold.
- Boundary to IOWAIT: ack rises in the cycle immediately after the last-phase strobe, so there is 0 idle gap.
- IOWAIT exit: i_IOPAUSE seen low at edge E, ack low and o_PHASE_EN[0] high in the cycle after E (1-cycle latency).
- STEPWAIT exit: i_STEP seen high at edge E, o_PHASE_EN[0] in the cycle after E. Exactly one full machine cycle runs, then STEPWAIT again if i_STEP_MODE is still high.
- o_CYCLE_COUNT updates on the edge leaving the last phase. It is visible in the first cycle of the following state.

## Test plan
- Reset/free-run, NUM_PHASES=3: release reset, idle inputs -> strobes 001,010,100 repeating from the 2nd edge. o_CYCLE_COUNT=3 after 9 strobes. Each toggle bit equals 1 after its first strobe.
- Hold, HOLD_PHASE=1: hold i_CUCPAUSE=1 for 3 cycles during phase 1 -> phase 1 strobed 4 times, toggle[1] back to 0. The machine cycle lasts 6 cycles and the count increments once.
- IO pause mid-cycle: assert i_IOPAUSE during phase 0 -> phases 1 and 2 still strobe, then ack=1 and strobes 0. Drop the request -> ack=0 and phase 0 on the next cycle. The count rises by exactly 1.
- Step mode: i_STEP_MODE=1 -> STEPWAIT after the cycle. Pulse i_STEP for 1 cycle -> exactly 3 strobes, then STEPWAIT. Raising i_IOPAUSE in STEPWAIT -> IOWAIT.
- Counter wrap, CNT_W=4: run 17 cycles -> o_CYCLE_COUNT reads 1.
- Async reset in phase 2 with ack low, and again in IOWAIT: assert i_RESET_N=0 between edges -> all outputs go to reset values immediately, without waiting for a clock edge. Re-run with NUM_PHASES=5, HOLD_PHASE=4 -> the hold on the last phase defers the count.
